gpr_bus_scheduler: RTL and testbench

GPR_BUS_SCHEDULER -- requirements
Module: gpr_bus_scheduler

---
 rtl/gpr_bus_scheduler_if.sv | 37 +++
 rtl/gpr_bus_scheduler.sv | 94 +++++++++
 tb/tb_gpr_bus_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gpr_bus_scheduler_if.sv
`default_nettype none
// ============================================================================
// gpr_bus_scheduler_if : requester, operand-select and GPR enable signals
// Rev 1.0
// ============================================================================
interface gpr_bus_scheduler_if;
    logic       cpu_req;
    logic       cpu_op;
    logic [1:0] cpu_sel;
    logic       cpu_gnt;
    logic       dbg_req;
    logic       dbg_op;
    logic [1:0] dbg_sel;
    logic       dbg_gnt;
    logic       lhs_en;
    logic [1:0] lhs_sel;
    logic       rhs_en;
    logic [1:0] rhs_sel;
    logic [3:0] a_main_n;
    logic [3:0] load_n;
    logic [3:0] a_lhs_n;
    logic [3:0] a_rhs_n;
    logic       busy;

    modport master (
        output cpu_req, cpu_op, cpu_sel, dbg_req, dbg_op, dbg_sel,
               lhs_en, lhs_sel, rhs_en, rhs_sel,
        input  cpu_gnt, dbg_gnt, a_main_n, load_n, a_lhs_n, a_rhs_n, busy
    );

    modport slave (
        input  cpu_req, cpu_op, cpu_sel, dbg_req, dbg_op, dbg_sel,
               lhs_en, lhs_sel, rhs_en, rhs_sel,
        output cpu_gnt, dbg_gnt, a_main_n, load_n, a_lhs_n, a_rhs_n, busy
    );
endinterface
`default_nettype wire

// File: rtl/gpr_bus_scheduler.sv
`default_nettype none
// ============================================================================
// gpr_bus_scheduler : round-robin MainBus scheduler for GPRs A..D + operand enables
// Rev 1.0
// ============================================================================
module gpr_bus_scheduler (
    input  wire logic          clk,
    input  wire logic          rst,
    gpr_bus_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [3:0] ALL_OFF = 4'b1111;

    state_t     state;
    logic       last_winner;
    logic       any_req;
    logic       winner;
    logic       win_op;
    logic [1:0] win_sel;

    function automatic logic [3:0] dec_n(input logic [1:0] s);
        return ~(4'b0001 << s);
    endfunction

    // On contention the requester that did not win last time is served.
    always_comb begin
        any_req = bus.cpu_req | bus.dbg_req;
        winner  = (bus.cpu_req && bus.dbg_req) ? ~last_winner : bus.dbg_req;
        win_op  = winner ? bus.dbg_op  : bus.cpu_op;
        win_sel = winner ? bus.dbg_sel : bus.cpu_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_winner  <= 1'b1;
            bus.cpu_gnt  <= 1'b0;
            bus.dbg_gnt  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.a_main_n <= ALL_OFF;
            bus.load_n   <= ALL_OFF;
        end else begin
            bus.cpu_gnt  <= 1'b0;
            bus.dbg_gnt  <= 1'b0;
            bus.a_main_n <= ALL_OFF;
            bus.load_n   <= ALL_OFF;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (any_req) begin
                        state       <= XFER;
                        bus.busy    <= 1'b1;
                        last_winner <= winner;
                        bus.cpu_gnt <= ~winner;
                        bus.dbg_gnt <= winner;
                        if (win_op) bus.load_n   <= dec_n(win_sel);
                        else        bus.a_main_n <= dec_n(win_sel);
                    end
                end
                XFER: begin
                    state    <= TURN;
                    bus.busy <= 1'b1;
                end
                TURN: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // Operand bus enables run free of the MainBus FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.a_lhs_n <= ALL_OFF;
            bus.a_rhs_n <= ALL_OFF;
        end else begin
            bus.a_lhs_n <= bus.lhs_en ? dec_n(bus.lhs_sel) : ALL_OFF;
            bus.a_rhs_n <= bus.rhs_en ? dec_n(bus.rhs_sel) : ALL_OFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpr_bus_scheduler.sv
`default_nettype none
// ============================================================================
// tb_gpr_bus_scheduler : directed vectors plus a randomised reference-model run
// Rev 1.0
// ============================================================================
module tb_gpr_bus_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    gpr_bus_scheduler_if bus ();

    gpr_bus_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic cg, input logic dg, input logic bz,
                           input logic [3:0] m, input logic [3:0] l,
                           input logic [3:0] lh, input logic [3:0] rh);
        chk(tag, {bus.cpu_gnt, bus.dbg_gnt, bus.busy, bus.a_main_n, bus.load_n, bus.a_lhs_n, bus.a_rhs_n},
                 {cg, dg, bz, m, l, lh, rh});
    endtask

    function automatic logic le1_low(input logic [3:0] v);
        return $countones(~v) <= 1;
    endfunction

    function automatic logic [3:0] dn(input logic [1:0] s);
        return ~(4'b0001 << s);
    endfunction

    // reference model state for the random run
    int         m_state;
    logic       m_last;
    logic [18:0] m_exp;
    int         gnt_cnt, xfer_cnt;

    task automatic model_step();
        logic       w, op, cg, dg, bz;
        logic [1:0] s;
        logic [3:0] mm, ll;
        cg = 1'b0; dg = 1'b0; mm = 4'hF; ll = 4'hF; bz = 1'b0;
        case (m_state)
            0: if (bus.cpu_req || bus.dbg_req) begin
                   w  = (bus.cpu_req && bus.dbg_req) ? ~m_last : bus.dbg_req;
                   op = w ? bus.dbg_op : bus.cpu_op;
                   s  = w ? bus.dbg_sel : bus.cpu_sel;
                   m_last = w; cg = ~w; dg = w; bz = 1'b1;
                   if (op) ll = dn(s); else mm = dn(s);
                   m_state = 1;
               end
            1: begin bz = 1'b1; m_state = 2; end
            default: m_state = 0;
        endcase
        m_exp = {cg, dg, bz, mm, ll,
                 bus.lhs_en ? dn(bus.lhs_sel) : 4'hF,
                 bus.rhs_en ? dn(bus.rhs_sel) : 4'hF};
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 0; bus.cpu_op = 0; bus.cpu_sel = 0;
        bus.dbg_req = 0; bus.dbg_op = 0; bus.dbg_sel = 0;
        bus.lhs_en = 0; bus.lhs_sel = 0; bus.rhs_en = 0; bus.rhs_sel = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick(); tick();
        chk_all("reset_state", 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);

        // single CPU load into GPR C
        rst = 1'b0;
        bus.cpu_req = 1; bus.cpu_op = 1; bus.cpu_sel = 2;
        tick();
        chk_all("cpu_load_xfer", 1, 0, 1, 4'hF, 4'b1011, 4'hF, 4'hF);
        bus.cpu_req = 0;
        tick();
        chk_all("cpu_load_turn", 0, 0, 1, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        chk_all("cpu_load_idle", 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);

        // debug request pulsed only during a CPU XFER is withdrawn
        bus.cpu_req = 1; bus.cpu_op = 0; bus.cpu_sel = 3;
        tick();
        chk_all("cpu_drive_xfer", 1, 0, 1, 4'b0111, 4'hF, 4'hF, 4'hF);
        bus.cpu_req = 0; bus.dbg_req = 1; bus.dbg_op = 1; bus.dbg_sel = 1;
        tick();
        bus.dbg_req = 0;
        chk_all("dbg_pulse_turn", 0, 0, 1, 4'hF, 4'hF, 4'hF, 4'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all("dbg_pulse_no_gnt", 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
        end

        // CPU load to GPR A while both operand buses read GPR A
        bus.cpu_req = 1; bus.cpu_op = 1; bus.cpu_sel = 0;
        bus.lhs_en = 1; bus.lhs_sel = 0; bus.rhs_en = 1; bus.rhs_sel = 0;
        tick();
        chk_all("load_and_operands", 1, 0, 1, 4'hF, 4'b1110, 4'b1110, 4'b1110);
        clear_inputs();
        tick();
        chk_all("operands_release", 0, 0, 1, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();

        // both requesters held from reset: CPU, DBG, CPU, DBG every 3 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cpu_req = 1; bus.cpu_op = 0; bus.cpu_sel = 1;
        bus.dbg_req = 1; bus.dbg_op = 1; bus.dbg_sel = 3;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 3 == 1) begin
                if ((k / 3) % 2 == 0)
                    chk_all("rr_cpu_slot", 1, 0, 1, 4'b1101, 4'hF, 4'hF, 4'hF);
                else
                    chk_all("rr_dbg_slot", 0, 1, 1, 4'hF, 4'b0111, 4'hF, 4'hF);
            end else begin
                chk_all("rr_gap", 0, 0, (k % 3 == 2), 4'hF, 4'hF, 4'hF, 4'hF);
            end
        end
        clear_inputs();
        tick();

        // reset during XFER forces everything off before the next edge
        bus.cpu_req = 1; bus.cpu_op = 0; bus.cpu_sel = 3;
        tick();
        chk_all("pre_reset_xfer", 1, 0, 1, 4'b0111, 4'hF, 4'hF, 4'hF);
        #2 rst = 1'b1;
        #1 chk_all("async_reset", 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        rst = 1'b0;
        tick();
        chk_all("regrant_after_reset", 1, 0, 1, 4'b0111, 4'hF, 4'hF, 4'hF);
        clear_inputs();
        tick(); tick();

        // random run against the reference model
        rst = 1'b1;
        m_state = 0; m_last = 1'b1; gnt_cnt = 0; xfer_cnt = 0;
        m_exp = {3'b000, 16'hFFFF};
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic [31:0] r;
            if (c > 0) begin
                chk("random_model",
                    {bus.cpu_gnt, bus.dbg_gnt, bus.busy, bus.a_main_n, bus.load_n, bus.a_lhs_n, bus.a_rhs_n},
                    m_exp);
                chk("random_invariants",
                    {le1_low(bus.a_main_n), le1_low(bus.load_n), le1_low(bus.a_lhs_n),
                     le1_low(bus.a_rhs_n), ((~bus.a_main_n & 4'hF) == 0) || ((~bus.load_n & 4'hF) == 0)},
                    5'b11111);
                gnt_cnt  += int'(bus.cpu_gnt) + int'(bus.dbg_gnt);
                xfer_cnt += (m_state == 1) ? 1 : 0;
            end
            r = $urandom;
            bus.cpu_req = r[0]; bus.cpu_op = r[1]; bus.cpu_sel = r[3:2];
            bus.dbg_req = r[4]; bus.dbg_op = r[5]; bus.dbg_sel = r[7:6];
            bus.lhs_en  = r[8]; bus.lhs_sel = r[10:9];
            bus.rhs_en  = r[11]; bus.rhs_sel = r[13:12];
            model_step();
            tick();
        end
        chk("gnt_vs_xfer_count", gnt_cnt, xfer_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
